// File: rtl/decapsulate_pkt.sv
// Receive-side decapsulation: filters on destination, enforces stop-and-wait sequence order,
// delivers in-order payloads over valid/ready and raises ack request/notification pulses.
module decapsulate_pkt #(
  parameter int DATA_WIDTH     = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
  parameter int ACK_WIDTH      = 1,
  parameter int SEQ_NUM_WIDTH  = 1,
  parameter int DFX_WIDTH      = 2,
  parameter int PKT_WIDTH      = DATA_DFX_WIDTH + ACK_WIDTH + SEQ_NUM_WIDTH*2 + DFX_WIDTH*2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_pkt_recv,
  input  logic [PKT_WIDTH-1:0]      pkt_data,
  input  logic [DFX_WIDTH-1:0]      local_dfx,
  output logic [DATA_DFX_WIDTH-1:0] dfx_data_out,
  output logic                      valid_dfx_data_out,
  input  logic                      dfx_data_ready,
  output logic                      ack_req,
  output logic [DFX_WIDTH-1:0]      ack_req_dst,
  output logic [SEQ_NUM_WIDTH-1:0]  ack_req_sn,
  output logic                      ack_rcvd,
  output logic [DFX_WIDTH-1:0]      ack_rcvd_src,
  output logic [SEQ_NUM_WIDTH-1:0]  ack_rcvd_sn,
  output logic [SEQ_NUM_WIDTH-1:0]  expected_sn,
  output logic [7:0]                drop_cnt,
  output logic                      pkt_overrun,
  input  logic                      clr_status
);

  localparam int DST_LSB = DFX_WIDTH;
  localparam int SN_LSB  = 2 * DFX_WIDTH;
  localparam int RN_LSB  = SN_LSB + SEQ_NUM_WIDTH;
  localparam int ACK_LSB = RN_LSB + SEQ_NUM_WIDTH;
  localparam int PAY_LSB = ACK_LSB + ACK_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PARSE   = 2'd1,
    DELIVER = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t                    state;
  logic [PKT_WIDTH-1:0]      pkt_q;
  logic [DFX_WIDTH-1:0]      pkt_src;
  logic [DFX_WIDTH-1:0]      pkt_dst;
  logic [SEQ_NUM_WIDTH-1:0]  pkt_sn;
  logic                      pkt_ack;
  logic [DATA_DFX_WIDTH-1:0] pkt_payload;
  logic                      unused_rn;
  logic                      busy_hit;
  logic                      dst_miss;
  logic [8:0]                drop_sum;
  logic [7:0]                drop_nxt;

  assign pkt_src     = pkt_q[0 +: DFX_WIDTH];
  assign pkt_dst     = pkt_q[DST_LSB +: DFX_WIDTH];
  assign pkt_sn      = pkt_q[SN_LSB +: SEQ_NUM_WIDTH];
  assign pkt_ack     = |pkt_q[ACK_LSB +: ACK_WIDTH];
  assign pkt_payload = pkt_q[PAY_LSB +: DATA_DFX_WIDTH];
  // Replays are resolved purely by sn; rn is carried but never interpreted.
  assign unused_rn   = ^pkt_q[RN_LSB +: SEQ_NUM_WIDTH];

  assign busy_hit = valid_pkt_recv && (state != IDLE);
  assign dst_miss = (state == PARSE) && (pkt_dst != local_dfx);

  // An overrun and a dst miss can land on the same edge, so both count.
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + 9'(busy_hit) + 9'(dst_miss);
    drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      pkt_q              <= '0;
      dfx_data_out       <= '0;
      valid_dfx_data_out <= 1'b0;
      ack_req            <= 1'b0;
      ack_req_dst        <= '0;
      ack_req_sn         <= '0;
      ack_rcvd           <= 1'b0;
      ack_rcvd_src       <= '0;
      ack_rcvd_sn        <= '0;
      expected_sn        <= '0;
      drop_cnt           <= '0;
      pkt_overrun        <= 1'b0;
    end else begin
      ack_req  <= 1'b0;
      ack_rcvd <= 1'b0;

      if (clr_status) begin
        drop_cnt    <= '0;
        pkt_overrun <= 1'b0;
      end else begin
        drop_cnt <= drop_nxt;
        if (busy_hit) pkt_overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (valid_pkt_recv) begin
            pkt_q <= pkt_data;
            state <= PARSE;
          end
        end
        PARSE: begin
          if (pkt_dst != local_dfx) begin
            state <= IDLE;
          end else if (pkt_ack) begin
            ack_rcvd     <= 1'b1;
            ack_rcvd_src <= pkt_src;
            ack_rcvd_sn  <= pkt_sn;
            state        <= IDLE;
          end else if (pkt_sn == expected_sn) begin
            dfx_data_out       <= pkt_payload;
            valid_dfx_data_out <= 1'b1;
            state              <= DELIVER;
          end else begin
            // Duplicate: re-ack so the sender can advance, payload discarded.
            ack_req     <= 1'b1;
            ack_req_dst <= pkt_src;
            ack_req_sn  <= pkt_sn;
            state       <= ACK;
          end
        end
        DELIVER: begin
          if (dfx_data_ready) begin
            valid_dfx_data_out <= 1'b0;
            expected_sn        <= expected_sn + SEQ_NUM_WIDTH'(1);
            ack_req            <= 1'b1;
            ack_req_dst        <= pkt_src;
            ack_req_sn         <= pkt_sn;
            state              <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decapsulate_pkt.sv
// Bench for decapsulate_pkt: directed plan with literal expectations plus random traffic,
// all checked each cycle against a timestamp-based packet model.
module tb_decapsulate_pkt;

  localparam int DDW   = 1034;
  localparam int PKT_W = 1041;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_pkt_recv = 1'b0;
  logic [PKT_W-1:0] pkt_data = '0;
  logic [1:0]      local_dfx = 2'd1;
  logic [DDW-1:0]  dfx_data_out;
  logic            valid_dfx_data_out;
  logic            dfx_data_ready = 1'b1;
  logic            ack_req;
  logic [1:0]      ack_req_dst;
  logic            ack_req_sn;
  logic            ack_rcvd;
  logic [1:0]      ack_rcvd_src;
  logic            ack_rcvd_sn;
  logic            expected_sn;
  logic [7:0]      drop_cnt;
  logic            pkt_overrun;
  logic            clr_status = 1'b0;

  decapsulate_pkt dut (
    .clk(clk), .rst_n(rst_n), .valid_pkt_recv(valid_pkt_recv), .pkt_data(pkt_data),
    .local_dfx(local_dfx), .dfx_data_out(dfx_data_out), .valid_dfx_data_out(valid_dfx_data_out),
    .dfx_data_ready(dfx_data_ready), .ack_req(ack_req), .ack_req_dst(ack_req_dst),
    .ack_req_sn(ack_req_sn), .ack_rcvd(ack_rcvd), .ack_rcvd_src(ack_rcvd_src),
    .ack_rcvd_sn(ack_rcvd_sn), .expected_sn(expected_sn), .drop_cnt(drop_cnt),
    .pkt_overrun(pkt_overrun), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DDW-1:0] act, input logic [DDW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (low 64 bits) at %0t", nm, act[63:0], exp[63:0], $time);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk(input logic [1:0] src, input logic [1:0] dst,
                                          input logic sn, input logic rn, input logic ack,
                                          input logic [DDW-1:0] pay);
    mk = {pay, ack, rn, sn, dst, src};
  endfunction

  function automatic logic [DDW-1:0] rnd_pay();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    rnd_pay = t[DDW-1:0];
  endfunction

  // Model: each accepted packet is decided one edge later; the node becomes free again
  // at a computed edge number, and anything arriving before then is an overrun.
  int             e = 0, free_at = 0, dec_at = 0, m_drop = 0, inc;
  bit             pending = 0, delivering = 0, busy;
  logic [1:0]     p_src, p_dst;
  logic           p_sn, p_ack;
  logic [DDW-1:0] p_pay;
  logic [DDW-1:0] m_data = '0;
  logic           m_valid = 0, m_ack_req = 0, m_ack_req_sn = 0, m_ack_rcvd = 0, m_rcvd_sn = 0;
  logic           m_exp_sn = 0, m_ovr = 0;
  logic [1:0]     m_ack_req_dst = 0, m_rcvd_src = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending = 0; delivering = 0; free_at = e + 1;
      m_data = '0; m_valid = 0; m_ack_req = 0; m_ack_req_dst = 0; m_ack_req_sn = 0;
      m_ack_rcvd = 0; m_rcvd_src = 0; m_rcvd_sn = 0; m_exp_sn = 0; m_drop = 0; m_ovr = 0;
    end else begin
      e++;
      busy = pending || delivering || (e < free_at);
      inc = 0;
      m_ack_req = 0;
      m_ack_rcvd = 0;
      if (delivering && dfx_data_ready && e > dec_at) begin
        m_valid = 0;
        m_exp_sn = ~m_exp_sn;
        m_ack_req = 1; m_ack_req_dst = p_src; m_ack_req_sn = p_sn;
        delivering = 0;
        free_at = e + 2;
      end
      if (pending && e == dec_at) begin
        pending = 0;
        if (p_dst != local_dfx) begin
          inc++; free_at = e + 1;
        end else if (p_ack) begin
          m_ack_rcvd = 1; m_rcvd_src = p_src; m_rcvd_sn = p_sn; free_at = e + 1;
        end else if (p_sn == m_exp_sn) begin
          m_data = p_pay; m_valid = 1; delivering = 1;
        end else begin
          m_ack_req = 1; m_ack_req_dst = p_src; m_ack_req_sn = p_sn; free_at = e + 2;
        end
      end
      if (valid_pkt_recv) begin
        if (busy) begin
          inc++; m_ovr = 1;
        end else begin
          pending = 1; dec_at = e + 1;
          {p_pay, p_ack} = {pkt_data[PKT_W-1:7], pkt_data[6]};
          p_sn = pkt_data[4]; p_dst = pkt_data[3:2]; p_src = pkt_data[1:0];
        end
      end
      m_drop = (m_drop + inc > 255) ? 255 : m_drop + inc;
      if (clr_status) begin
        m_drop = 0; m_ovr = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", valid_dfx_data_out, m_valid);
      chk("data", dfx_data_out, m_data);
      chk("ack_req", ack_req, m_ack_req);
      chk("ack_req_dst", ack_req_dst, m_ack_req_dst);
      chk("ack_req_sn", ack_req_sn, m_ack_req_sn);
      chk("ack_rcvd", ack_rcvd, m_ack_rcvd);
      chk("ack_rcvd_src", ack_rcvd_src, m_rcvd_src);
      chk("ack_rcvd_sn", ack_rcvd_sn, m_rcvd_sn);
      chk("expected_sn", expected_sn, m_exp_sn);
      chk("drop_cnt", drop_cnt, m_drop[7:0]);
      chk("pkt_overrun", pkt_overrun, m_ovr);
    end
  end

  // Strobes the packet for edge N; returns 1ns into cycle N+1.
  task automatic send(input logic [PKT_W-1:0] p);
    @(posedge clk); #1;
    valid_pkt_recv = 1'b1;
    pkt_data = p;
    @(posedge clk); #1;
    valid_pkt_recv = 1'b0;
  endtask

  logic [DDW-1:0] pay5a5, pay_stall;

  initial begin
    pay5a5 = DDW'('h5A5);
    pay_stall = rnd_pay();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_valid", valid_dfx_data_out, 0);
    chk("rst_expected_sn", expected_sn, 0);
    chk("rst_drop", drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // In-order data packet
    send(mk(2'd2, 2'd1, 1'b0, 1'b0, 1'b0, pay5a5));
    @(negedge clk);
    @(negedge clk);
    chk("t1_valid_n2", valid_dfx_data_out, 1);
    chk("t1_data_n2", dfx_data_out, pay5a5);
    @(negedge clk);
    chk("t1_ack_req_n3", ack_req, 1);
    chk("t1_ack_dst", ack_req_dst, 2);
    chk("t1_ack_sn", ack_req_sn, 0);
    chk("t1_valid_n3", valid_dfx_data_out, 0);
    chk("t1_exp_sn", expected_sn, 1);

    // Duplicate replay
    send(mk(2'd2, 2'd1, 1'b0, 1'b0, 1'b0, pay5a5));
    @(negedge clk);
    @(negedge clk);
    chk("t2_ack_req_n2", ack_req, 1);
    chk("t2_ack_sn", ack_req_sn, 0);
    chk("t2_valid", valid_dfx_data_out, 0);
    chk("t2_exp_sn", expected_sn, 1);
    chk("t2_drop", drop_cnt, 0);

    // Ack packet
    send(mk(2'd3, 2'd1, 1'b1, 1'b0, 1'b1, rnd_pay()));
    @(negedge clk);
    @(negedge clk);
    chk("t3_ack_rcvd", ack_rcvd, 1);
    chk("t3_rcvd_src", ack_rcvd_src, 3);
    chk("t3_rcvd_sn", ack_rcvd_sn, 1);
    chk("t3_ack_req", ack_req, 0);

    // Destination mismatch, saturation, clear priority
    send(mk(2'd0, 2'd2, 1'b1, 1'b0, 1'b0, rnd_pay()));
    @(negedge clk);
    @(negedge clk);
    chk("t4_drop_1", drop_cnt, 1);
    for (int i = 0; i < 299; i++) send(mk(2'd0, 2'd2, 1'b1, 1'b0, 1'b0, pay5a5));
    @(negedge clk);
    @(negedge clk);
    chk("t4_drop_sat", drop_cnt, 255);
    send(mk(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, pay5a5));
    clr_status = 1'b1;
    @(posedge clk); #1;
    clr_status = 1'b0;
    @(negedge clk);
    chk("t4_clr_drop", drop_cnt, 0);

    // Stalled delivery with an overrun packet
    dfx_data_ready = 1'b0;
    send(mk(2'd1, 2'd1, 1'b1, 1'b0, 1'b0, pay_stall));
    send(mk(2'd3, 2'd1, 1'b0, 1'b0, 1'b0, rnd_pay()));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_valid_held", valid_dfx_data_out, 1);
    chk("t5_data_held", dfx_data_out, pay_stall);
    chk("t5_overrun", pkt_overrun, 1);
    chk("t5_drop", drop_cnt, 1);
    chk("t5_exp_sn_stall", expected_sn, 1);
    @(posedge clk); #1;
    dfx_data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_valid_done", valid_dfx_data_out, 0);
    chk("t5_ack_req", ack_req, 1);
    chk("t5_ack_dst", ack_req_dst, 1);
    chk("t5_exp_sn", expected_sn, 0);

    // Reset during DELIVER
    repeat (2) @(posedge clk);
    dfx_data_ready = 1'b0;
    send(mk(2'd2, 2'd1, 1'b0, 1'b0, 1'b0, rnd_pay()));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_valid", valid_dfx_data_out, 0);
    chk("t6_data", dfx_data_out, 0);
    chk("t6_overrun", pkt_overrun, 0);
    chk("t6_exp_sn", expected_sn, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dfx_data_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_no_ack", ack_req, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst_n          = ($urandom_range(0, 599) != 0);
      valid_pkt_recv = ($urandom_range(0, 99) < 35);
      pkt_data       = mk(2'($urandom), ($urandom_range(0, 9) < 7) ? local_dfx : 2'($urandom),
                          1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), rnd_pay());
      dfx_data_ready = ($urandom_range(0, 9) < 6);
      clr_status     = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid_pkt_recv = 1'b0;
    clr_status = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/decapsulate_pkt.md
# decapsulate_pkt

Receive-side counterpart of the packet encapsulation path. It accepts one full packet per transfer from the defragment stage, checks the destination, and splits the packet into DFX payload, header fields and acknowledgement information. It enforces stop-and-wait sequence-number ordering, delivers in-order payloads to the DFX sink over a valid/ready handshake, and raises ack requests and ack notifications to the send/receive controllers.

## Interface
- DATA_WIDTH, 1024, raw data width
- ADDR_WIDTH, 10, address width carried with data
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH, payload width
- ACK_WIDTH, 1, ack flag width
- SEQ_NUM_WIDTH, 1, sequence-number width
- DFX_WIDTH, 2, DFX id width
- PKT_WIDTH, DATA_DFX_WIDTH+ACK_WIDTH+SEQ_NUM_WIDTH*2+DFX_WIDTH*2, packet width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_pkt_recv  in  1  one-cycle strobe: pkt_data is valid
- pkt_data  in  PKT_WIDTH  received packet
- local_dfx  in  DFX_WIDTH  this node's DFX id (quasi-static)
- dfx_data_out  out  DATA_DFX_WIDTH  delivered payload
- valid_dfx_data_out  out  1  payload valid
- dfx_data_ready  in  1  sink accepts payload
- ack_req  out  1  one-cycle pulse: send ack for received data packet
- ack_req_dst  out  DFX_WIDTH  ack destination (source of the data packet)
- ack_req_sn  out  SEQ_NUM_WIDTH  sequence number being acked
- ack_rcvd  out  1  one-cycle pulse: ack packet received
- ack_rcvd_src  out  DFX_WIDTH  sender of the ack
- ack_rcvd_sn  out  SEQ_NUM_WIDTH  acked sequence number
- expected_sn  out  SEQ_NUM_WIDTH  next in-order sequence number
- drop_cnt  out  8  dropped-packet counter, saturating
- pkt_overrun  out  1  sticky: packet arrived while busy
- clr_status  in  1  clears drop_cnt and pkt_overrun

## Operation
- Packet field layout, LSB first: src [DFX_WIDTH-1:0]; dst [2*DFX_WIDTH-1:DFX_WIDTH]; sn (SEQ_NUM_WIDTH); rn (SEQ_NUM_WIDTH); ack (1); payload (DATA_DFX_WIDTH) in the MSBs.
- The rn field is not interpreted. A replayed packet is handled by sn alone.
- States: IDLE, PARSE, DELIVER, ACK. Encoding is 2 bits. Unused codes go to IDLE.
- IDLE: valid_pkt_recv registers pkt_data into the packet register and moves to PARSE.
- PARSE: decision made on the registered packet.
  - dst != local_dfx: drop_cnt increments; go to IDLE.
  - ack=1: register ack_rcvd=1, ack_rcvd_src=src, ack_rcvd_sn=sn; go to IDLE.
  - ack=0 and sn == expected_sn: register dfx_data_out=payload and valid_dfx_data_out=1; go to DELIVER.
  - ack=0 and sn != expected_sn: duplicate. The payload is discarded and drop_cnt is not incremented; go to ACK.
- DELIVER: dfx_data_out and valid_dfx_data_out hold until valid && ready is seen at a clock edge. On that edge, valid_dfx_data_out goes to 0, expected_sn increments modulo 2^SEQ_NUM_WIDTH, and the FSM goes to ACK.
- ACK: ack_req=1 for exactly this cycle, with ack_req_dst = packet src and ack_req_sn = packet sn. Then go to IDLE.
- valid_pkt_recv in any state other than IDLE: the packet is ignored, pkt_overrun is set, drop_cnt increments, and the current packet is unaffected.
- drop_cnt saturates at 255. clr_status has priority over any increment or set in the same cycle.
- ack_rcvd_*, ack_req_*, and dfx_data_out hold their last values when not strobed.

## Timing
- Reset: FSM IDLE, packet register 0, all outputs 0, expected_sn=0.
- Reset asserted mid-operation abandons the packet immediately, including in DELIVER. No ack is issued.
- valid_pkt_recv is sampled at edge N. PARSE occupies cycle N+1.
- Data packet, in order: valid_dfx_data_out high from N+2. With ready high at N+2, ack_req is high in N+3 and IDLE is reached at N+4. The earliest next packet accept is N+4.
- Duplicate data packet: ack_req high in N+2; IDLE at N+3.
- Ack packet: ack_rcvd high in N+2 only; IDLE at N+2.
- dst mismatch: drop_cnt updated at N+2; IDLE at N+2.
- ready low stalls DELIVER indefinitely. expected_sn changes only on the handshake edge.

## Test plan
- local_dfx=1; packet src=2, dst=1, sn=0, ack=0, payload=0x5A5; ready=1. Required: valid_dfx_data_out high one cycle at N+2 with 0x5A5; expected_sn becomes 1; ack_req at N+3 with dst=2, sn=0.
- Same packet repeated with sn=0 after expected_sn=1. Required: no payload output; ack_req at N+2 with sn=0; expected_sn stays 1; drop_cnt unchanged.
- Ack packet src=3, dst=1, ack=1, sn=1. Required: ack_rcvd pulse at N+2 with src=3, sn=1; no payload, no ack_req.
- Packet dst=2 with local_dfx=1. Required: no outputs; drop_cnt increments 0→1. After 300 such packets, drop_cnt=255. clr_status together with a drop gives drop_cnt=0.
- In-order data with ready held low 5 cycles, plus a second valid_pkt_recv during the stall. Required: payload held stable; pkt_overrun=1; drop_cnt+1; delivery completes when ready rises and the ack follows next cycle.
- rst_n pulsed low during DELIVER. Required: all outputs 0 and expected_sn=0 immediately; no ack_req after release.
